// File: rtl/md_unit_if.sv
// md_unit_if -- operand/control/result bundle between the execute stage and
// the multiply/divide unit.
//   A, B     : register-file operands rs / rt
//   MDUCtrl  : operation select, qualified by Start
//   Start    : one-cycle request strobe
//   HI, LO   : architectural HI/LO registers
//   Busy     : multi-cycle operation in flight
// master = execute stage / hazard logic, slave = md_unit.
interface md_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUCtrl;
  logic        Start;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;

  modport master (
    output A, B, MDUCtrl, Start,
    input  HI, LO, Busy
  );

  modport slave (
    input  A, B, MDUCtrl, Start,
    output HI, LO, Busy
  );
endinterface

// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit feeding the HI/LO registers.
//   clk    : single clock, all state on the rising edge
//   reset  : synchronous active-high, clears all state
//   mdu    : md_unit_if.slave (A, B, MDUCtrl, Start in; HI, LO, Busy out)
// The result is computed when the request is accepted and parked in a
// pending register; a down-counter holds Busy high for MULT_CYCLES or
// DIV_CYCLES and the pending value is committed on its terminal count.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU (codes 0111/1000,
// {HI,LO} += A*B); otherwise those codes are no-ops.
//
// state | meaning
// IDLE  | accepting Start; MTHI/MTLO write immediately
// RUN   | counting down, pending result held, Start ignored
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  md_unit_if.slave mdu
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      pending_q;
  logic             skip_q;
  logic [31:0]      hi_q, lo_q;

  logic is_mul, is_div, is_signed, op_mthi, op_mtlo;
`ifdef MDU_MADD_EN
  logic is_madd;
`endif
  logic launch, finish, mthi_we, mtlo_we;

  // operation decode
  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    op_mthi   = 1'b0;
    op_mtlo   = 1'b0;
`ifdef MDU_MADD_EN
    is_madd   = 1'b0;
`endif
    case (mdu.MDUCtrl)
      4'b0001: begin is_mul = 1'b1; is_signed = 1'b1; end
      4'b0010: is_mul = 1'b1;
      4'b0011: begin is_div = 1'b1; is_signed = 1'b1; end
      4'b0100: is_div = 1'b1;
      4'b0101: op_mthi = 1'b1;
      4'b0110: op_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      4'b0111: begin is_mul = 1'b1; is_madd = 1'b1; is_signed = 1'b1; end
      4'b1000: begin is_mul = 1'b1; is_madd = 1'b1; end
`endif
      default: ;
    endcase
  end

  // multiply: extending both operands to 64 bits makes the low 64 bits of
  // the product correct for both signed and unsigned forms
  logic [63:0] ext_a, ext_b, prod, mul_res;
  always_comb begin
    ext_a   = is_signed ? {{32{mdu.A[31]}}, mdu.A} : {32'd0, mdu.A};
    ext_b   = is_signed ? {{32{mdu.B[31]}}, mdu.B} : {32'd0, mdu.B};
    prod    = ext_a * ext_b;
    mul_res = prod;
`ifdef MDU_MADD_EN
    if (is_madd) mul_res = {hi_q, lo_q} + prod;
`endif
  end

  // divide on magnitudes, then restore signs; this also yields the
  // 0x80000000 / -1 wrap case without a signed overflow
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  always_comb begin
    a_neg  = is_signed & mdu.A[31];
    b_neg  = is_signed & mdu.B[31];
    b_zero = (mdu.B == 32'd0);
    a_mag  = a_neg ? (~mdu.A + 32'd1) : mdu.A;
    b_mag  = b_neg ? (~mdu.B + 32'd1) : mdu.B;
    b_safe = b_zero ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mdu.Start && (is_mul || is_div)) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs / datapath strobes
  always_comb begin
    launch  = (state_q == IDLE) && mdu.Start && (is_mul || is_div);
    mthi_we = (state_q == IDLE) && mdu.Start && op_mthi;
    mtlo_we = (state_q == IDLE) && mdu.Start && op_mtlo;
    finish  = (state_q == RUN) && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      pending_q <= '0;
      skip_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (launch) begin
        cnt_q     <= is_div ? DIV_LOAD : MULT_LOAD;
        pending_q <= is_div ? {rem, quo} : mul_res;
        skip_q    <= is_div && b_zero;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q - CNT_LAST;
      end
      if (finish && !skip_q) {hi_q, lo_q} <= pending_q;
      if (mthi_we) hi_q <= mdu.A;
      if (mtlo_we) lo_q <= mdu.A;
    end
  end

  assign mdu.HI   = hi_q;
  assign mdu.LO   = lo_q;
  assign mdu.Busy = (state_q == RUN);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- directed plus randomized bench for md_unit against a
// behavioural HI/LO model built from plain 64-bit arithmetic.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  md_unit_if mdu_bus();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu_bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: updates exp_hi/exp_lo, returns the expected busy length
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    n = 0;
    case (op)
      4'd1: begin p = sa * sb; {exp_hi, exp_lo} = p; n = MC; end
      4'd2: begin p = ua * ub; {exp_hi, exp_lo} = p; n = MC; end
      4'd3: begin
        n = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
      end
      4'd4: begin
        n = DC;
        if (b != 0) begin p = ua / ub; exp_lo = p[31:0]; p = ua % ub; exp_hi = p[31:0]; end
      end
      4'd5: exp_hi = a;
      4'd6: exp_lo = a;
`ifdef MDU_MADD_EN
      4'd7: begin p = {exp_hi, exp_lo}; p = p + longint'(sa * sb); {exp_hi, exp_lo} = p; n = MC; end
      4'd8: begin p = {exp_hi, exp_lo}; p = p + ua * ub; {exp_hi, exp_lo} = p; n = MC; end
`endif
      default: ;
    endcase
  endtask

  // called just after a negedge; returns just after a negedge
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n, cnt;
    mdu_bus.MDUCtrl = op;
    mdu_bus.A       = a;
    mdu_bus.B       = b;
    mdu_bus.Start   = 1'b1;
    @(negedge clk);
    mdu_bus.Start   = 1'b0;
    mdu_bus.MDUCtrl = 4'd0;
    cnt = 0;
    while (mdu_bus.Busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    model(op, a, b, n);
    chk({tag, "_busy"}, 64'(cnt), 64'(n));
    chk({tag, "_hi"}, {32'd0, mdu_bus.HI}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, mdu_bus.LO}, {32'd0, exp_lo});
  endtask

  initial begin
    int cnt, n;
    logic [3:0]  op;
    logic [31:0] a, b;

    reset = 1'b1;
    mdu_bus.A = '0;
    mdu_bus.B = '0;
    mdu_bus.MDUCtrl = '0;
    mdu_bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", {32'd0, mdu_bus.HI}, 64'd0);
    chk("rst_lo", {32'd0, mdu_bus.LO}, 64'd0);
    chk("rst_busy", {63'd0, mdu_bus.Busy}, 64'd0);
    reset = 1'b0;

    run_op("mthi", 4'd5, 32'h12345678, 32'h0);
    run_op("mult", 4'd1, 32'hFFFFFFFF, 32'h2);
    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'h2);
    run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'h2);
    run_op("divu", 4'd4, 32'h7, 32'h2);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
    run_op("pre_hi", 4'd5, 32'hA, 32'h0);
    run_op("pre_lo", 4'd6, 32'hB, 32'h0);
    run_op("divu_z", 4'd4, 32'h1234, 32'h0);
    run_op("div_z", 4'd3, 32'h80000000, 32'h0);

    // Start while busy: second MULT and an MTLO must both be dropped
    mdu_bus.MDUCtrl = 4'd1; mdu_bus.A = 32'd3; mdu_bus.B = 32'd5; mdu_bus.Start = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (mdu_bus.Busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == 1) begin
        mdu_bus.MDUCtrl = 4'd1; mdu_bus.A = 32'd7; mdu_bus.B = 32'd7; mdu_bus.Start = 1'b1;
      end else if (cnt == 2) begin
        mdu_bus.MDUCtrl = 4'd6; mdu_bus.A = 32'h55; mdu_bus.B = 32'd0; mdu_bus.Start = 1'b1;
      end else begin
        mdu_bus.Start = 1'b0; mdu_bus.MDUCtrl = 4'd0;
      end
      @(negedge clk);
    end
    mdu_bus.Start = 1'b0;
    model(4'd1, 32'd3, 32'd5, n);
    chk("ign_busy", 64'(cnt), 64'(n));
    chk("ign_hi", {32'd0, mdu_bus.HI}, {32'd0, exp_hi});
    chk("ign_lo", {32'd0, mdu_bus.LO}, {32'd0, exp_lo});

    // reset in the third busy cycle aborts the pending write
    mdu_bus.MDUCtrl = 4'd1; mdu_bus.A = 32'hFFFFFFFF; mdu_bus.B = 32'd2; mdu_bus.Start = 1'b1;
    @(negedge clk);
    mdu_bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    chk("abort_busy", {63'd0, mdu_bus.Busy}, 64'd0);
    chk("abort_hi", {32'd0, mdu_bus.HI}, 64'd0);
    chk("abort_lo", {32'd0, mdu_bus.LO}, 64'd0);
    repeat (8) @(negedge clk);
    chk("late_busy", {63'd0, mdu_bus.Busy}, 64'd0);
    chk("late_hi", {32'd0, mdu_bus.HI}, 64'd0);
    chk("late_lo", {32'd0, mdu_bus.LO}, 64'd0);

    // reset beats a simultaneous MTHI
    run_op("pre_hi2", 4'd5, 32'h77, 32'h0);
    mdu_bus.MDUCtrl = 4'd5; mdu_bus.A = 32'h99; mdu_bus.Start = 1'b1; reset = 1'b1;
    @(negedge clk);
    mdu_bus.Start = 1'b0; reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    chk("rst_win_hi", {32'd0, mdu_bus.HI}, 64'd0);
    chk("rst_win_busy", {63'd0, mdu_bus.Busy}, 64'd0);

    // MADD: accumulates with the macro, no-op without it (model covers both)
    run_op("madd_phi", 4'd5, 32'h0, 32'h0);
    run_op("madd_plo", 4'd6, 32'h5, 32'h0);
    run_op("madd", 4'd7, 32'd3, 32'd4);
    run_op("maddu", 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("undef", 4'd15, 32'hDEAD, 32'hBEEF);

    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("rand", op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the MIPS datapath's execute stage. It consumes the same two register-file operands as the ALU and produces results into dedicated HI/LO registers. Multiply and divide take several cycles, and a Busy flag lets the hazard logic stall MFHI/MFLO/MTHI/MTLO and further mult/div instructions. MFHI/MFLO read HI and LO directly.

## Interface
- MULT_CYCLES, 5: cycles Busy stays high for MULT/MULTU (and MADD/MADDU); must be ≥1
- DIV_CYCLES, 10: cycles Busy stays high for DIV/DIVU; must be ≥1
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source)
- B  input  32  operand rt (divisor / multiplier)
- MDUCtrl  input  4  operation select (encoding below)
- Start  input  1  qualifies MDUCtrl for one cycle
- HI  output  32  HI register
- LO  output  32  LO register
- Busy  output  1  operation in flight

## Operation
- MDUCtrl encoding:
  - 4'b0000: none
  - 4'b0001: MULT
  - 4'b0010: MULTU
  - 4'b0011: DIV
  - 4'b0100: DIVU
  - 4'b0101: MTHI
  - 4'b0110: MTLO
  - 4'b0111: MADD (macro only)
  - 4'b1000: MADDU (macro only)
  - Any other value: no-op.
- State machine: IDLE, RUN.
  - IDLE→RUN: Start=1, Busy=0, and a mult/div/madd op is selected. A and B are captured, the 64-bit result is computed into an internal pending register, and a down-counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - RUN→IDLE: when the counter reaches the last cycle, pending is written to {HI,LO}.
- MULT/MULTU: {HI,LO} = signed/unsigned 32×32→64 product.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- Divide by zero (B=0): the unit still goes busy for DIV_CYCLES, and HI and LO are left unchanged at completion.
- MTHI/MTLO with Start=1 and Busy=0: HI or LO = A at that edge. Busy is not asserted.
- Start=1 while Busy=1: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this does not occur; the unit does not queue it.
- Start=1 with a no-op or undefined code: no state change.
- HI/LO outputs are always the architectural registers. The pending result is not visible until completion.

## Timing
- Reset values: HI=0, LO=0, Busy=0, state=IDLE, counter=0.
- Start accepted at edge t: Busy=1 from t+1 through t+N, where N is MULT_CYCLES or DIV_CYCLES.
- At edge t+N, HI and LO take the new value and Busy falls. A new Start is accepted at edge t+N+1 at the earliest.
- Busy is a registered output with no combinational path from Start. Stall logic uses Start|Busy.
- Reset mid-operation aborts: the pending result is discarded, HI=LO=0, Busy=0 on the next edge.
- Reset and Start at the same edge: reset wins.
- MTHI/MTLO take effect at their own edge (zero latency). The new value is visible on HI/LO in the following cycle.

## Configuration
- MDU_MADD_EN defined:
  - Codes 4'b0111 (MADD) and 4'b1000 (MADDU) are legal.
  - {HI,LO} = {HI,LO} + A×B (signed/unsigned, mod 2^64).
  - The accumulate base is the HI/LO value at the Start edge.
  - Busy lasts MULT_CYCLES.
- MDU_MADD_EN undefined: 4'b0111 and 4'b1000 are no-ops, like undefined codes.

## Test plan
- Reset checks:
  - Reset: HI=0, LO=0, Busy=0.
  - MTHI A=0x12345678: HI=0x12345678 next cycle, Busy stays 0.
- Multiply, A=0xFFFFFFFF, B=0x00000002, Start=1:
  - MULT: Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU: HI=0x00000001, LO=0xFFFFFFFE.
- Divide:
  - DIV A=0xFFFFFFF9 (−7), B=2: after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7, B=2: LO=3, HI=1.
  - DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero:
  - Preload HI=0xA, LO=0xB, then DIVU B=0: Busy 10 cycles, and HI=0xA, LO=0xB afterwards.
- Busy and reset behaviour:
  - During Busy, a MULT Start and an MTLO A=0x55 are both ignored, and the original result lands.
  - Reset asserted at busy cycle 3: HI=LO=0, Busy=0 next cycle, and no late write.
- MADD (MDU_MADD_EN defined):
  - Preload HI=0, LO=5, then MADD A=3, B=4: LO=0x11, HI=0.
  - Without the macro, the same stimulus leaves LO=5 and Busy=0.
